jtag_tap_core: RTL and testbench

//  Parametrised IEEE 1149.1 TAP: 16-state controller, IR_WIDTH instruction register, decode, internal BYPASS/IDCODE/USER DRs.

---
 rtl/jtag_tap_core.sv | 189 ++++++++++++++++++
 tb/tb_jtag_tap_core.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_core.sv
// jtag_tap_core: IEEE 1149.1 TAP with IR decode, BYPASS/USER DRs (IDCODE DR when JTAG_IDCODE_EN is defined), external BSR strobes.
// State and shifts on tck rise, tdo registered on tck fall (half-cycle latency); no backpressure, tck/tms pace everything.
module jtag_tap_core #(
  parameter int unsigned          IR_WIDTH   = 4,
  parameter int unsigned          USER_WIDTH = 8,
  parameter logic [31:0]          IDCODE_VAL = 32'h1000_0001,
  parameter logic [IR_WIDTH-1:0]  OP_EXTEST  = 'h0,
  parameter logic [IR_WIDTH-1:0]  OP_IDCODE  = 'h1,
  parameter logic [IR_WIDTH-1:0]  OP_SAMPLE  = 'h2,
  parameter logic [IR_WIDTH-1:0]  OP_USER    = 'h3
) (
  input  logic                  tck,
  input  logic                  trst,
  input  logic                  tms,
  input  logic                  tdi,
  output logic                  tdo,
  output logic                  tdo_en,
  output logic                  bsr_tdi,
  input  logic                  bsr_tdo,
  output logic                  bsr_capture,
  output logic                  bsr_shift,
  output logic                  bsr_update,
  output logic                  bsr_mode,
  input  logic [USER_WIDTH-1:0] user_dr_in,
  output logic [USER_WIDTH-1:0] user_dr_out,
  output logic                  user_update
);

  if (IR_WIDTH < 2 || USER_WIDTH < 1 || IDCODE_VAL[0] != 1'b1 ||
      OP_EXTEST == OP_IDCODE || OP_EXTEST == OP_SAMPLE || OP_EXTEST == OP_USER ||
      OP_IDCODE == OP_SAMPLE || OP_IDCODE == OP_USER || OP_SAMPLE == OP_USER) begin : g_bad_cfg
    $error("jtag_tap_core: invalid parameter set");
  end

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SHF_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SHF_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tap_state_t;

  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = {{(IR_WIDTH-1){1'b0}}, 1'b1};
`ifdef JTAG_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] RESET_OP = OP_IDCODE;
`else
  localparam logic [IR_WIDTH-1:0] RESET_OP = '1;
`endif

  tap_state_t            state_q, state_d;
  logic [IR_WIDTH-1:0]   ir, ir_shift;
  logic                  bypass_q;
  logic [USER_WIDTH-1:0] user_sh;
  logic                  sel_bsr, sel_user, sel_bypass, dr_lsb;

  always_ff @(posedge tck or posedge trst) begin
    if (trst) state_q <= TLR;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:    state_d = tms ? TLR    : RTI;
      RTI:    state_d = tms ? SEL_DR : RTI;
      SEL_DR: state_d = tms ? SEL_IR : CAP_DR;
      CAP_DR: state_d = tms ? EX1_DR : SHF_DR;
      SHF_DR: state_d = tms ? EX1_DR : SHF_DR;
      EX1_DR: state_d = tms ? UPD_DR : PAU_DR;
      PAU_DR: state_d = tms ? EX2_DR : PAU_DR;
      EX2_DR: state_d = tms ? UPD_DR : SHF_DR;
      UPD_DR: state_d = tms ? SEL_DR : RTI;
      SEL_IR: state_d = tms ? TLR    : CAP_IR;
      CAP_IR: state_d = tms ? EX1_IR : SHF_IR;
      SHF_IR: state_d = tms ? EX1_IR : SHF_IR;
      EX1_IR: state_d = tms ? UPD_IR : PAU_IR;
      PAU_IR: state_d = tms ? EX2_IR : PAU_IR;
      EX2_IR: state_d = tms ? UPD_IR : SHF_IR;
      UPD_IR: state_d = tms ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
  end

  // The decoded instruction only moves in Update-IR or TLR, so all selects are stable during a DR scan.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      ir       <= RESET_OP;
      ir_shift <= '0;
    end else begin
      case (state_q)
        TLR:    ir <= RESET_OP;
        CAP_IR: ir_shift <= IR_CAPTURE;
        SHF_IR: begin
          ir_shift           <= ir_shift >> 1;
          ir_shift[IR_WIDTH-1] <= tdi;
        end
        UPD_IR: ir <= ir_shift;
        default: ;
      endcase
    end
  end

  assign sel_bsr  = (ir == OP_EXTEST) || (ir == OP_SAMPLE);
  assign sel_user = (ir == OP_USER);

`ifdef JTAG_IDCODE_EN
  logic        sel_idcode;
  logic [31:0] idcode_sh;

  assign sel_idcode = (ir == OP_IDCODE);
  assign sel_bypass = !(sel_bsr || sel_user || sel_idcode);

  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      idcode_sh <= '0;
    end else if (sel_idcode && state_q == CAP_DR) begin
      idcode_sh <= IDCODE_VAL;
    end else if (sel_idcode && state_q == SHF_DR) begin
      idcode_sh     <= idcode_sh >> 1;
      idcode_sh[31] <= tdi;
    end
  end
`else
  assign sel_bypass = !(sel_bsr || sel_user);
`endif

  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      bypass_q <= 1'b0;
      user_sh  <= '0;
    end else if (state_q == CAP_DR) begin
      if (sel_bypass) bypass_q <= 1'b0;
      if (sel_user)   user_sh  <= user_dr_in;
    end else if (state_q == SHF_DR) begin
      if (sel_bypass) bypass_q <= tdi;
      if (sel_user) begin
        user_sh               <= user_sh >> 1;
        user_sh[USER_WIDTH-1] <= tdi;
      end
    end
  end

  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      user_dr_out <= '0;
      user_update <= 1'b0;
    end else begin
      user_update <= (state_q == UPD_DR) && sel_user;
      if ((state_q == UPD_DR) && sel_user) user_dr_out <= user_sh;
    end
  end

  always_comb begin
    dr_lsb = bypass_q;
    if (sel_bsr)       dr_lsb = bsr_tdo;
    else if (sel_user) dr_lsb = user_sh[0];
`ifdef JTAG_IDCODE_EN
    else if (sel_idcode) dr_lsb = idcode_sh[0];
`endif
  end

  // Falling-edge tdo gives the downstream device a full half-cycle of setup before its rising edge.
  always_ff @(negedge tck or posedge trst) begin
    if (trst) begin
      tdo    <= 1'b0;
      tdo_en <= 1'b0;
    end else begin
      case (state_q)
        SHF_IR: begin
          tdo    <= ir_shift[0];
          tdo_en <= 1'b1;
        end
        SHF_DR: begin
          tdo    <= dr_lsb;
          tdo_en <= 1'b1;
        end
        default: begin
          tdo    <= 1'b0;
          tdo_en <= 1'b0;
        end
      endcase
    end
  end

  assign bsr_tdi     = tdi;
  assign bsr_capture = sel_bsr && (state_q == CAP_DR);
  assign bsr_shift   = sel_bsr && (state_q == SHF_DR);
  assign bsr_update  = sel_bsr && (state_q == UPD_DR);
  assign bsr_mode    = (ir == OP_EXTEST);

endmodule

// File: tb/tb_jtag_tap_core.sv
// Scoreboard bench for jtag_tap_core: a table-driven TAP model queues expected tdo bits and USER updates,
// a monitor pops them whenever the DUT drives tdo_en or user_update.
module tb_jtag_tap_core;
  localparam int UW = 8;
  localparam int IRW = 4;
  localparam logic [31:0] IDV = 32'h1000_0001;
  localparam int K_BYP = 0, K_ID = 1, K_USER = 2, K_BSR = 3;
  // Standard TAP graph; index order: TLR RTI SELDR CAPDR SHFDR EX1DR PAUDR EX2DR UPDDR SELIR CAPIR SHFIR EX1IR PAUIR EX2IR UPDIR
  localparam int NXT0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  localparam int NXT1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
`ifdef JTAG_IDCODE_EN
  localparam logic [IRW-1:0] RST_OP = 4'h1;
`else
  localparam logic [IRW-1:0] RST_OP = 4'hF;
`endif

  logic tck = 1'b0;
  logic trst, tms, tdi, tdo, tdo_en, bsr_tdi, bsr_tdo;
  logic bsr_capture, bsr_shift, bsr_update, bsr_mode, user_update;
  logic [UW-1:0] user_dr_in, user_dr_out;

  int n_tests = 0;
  int n_fail = 0;
  int upd_seen = 0;
  bit exp_q[$];
  bit obs_q[$];
  logic [UW-1:0] upd_q[$];

  int m_state;
  logic [IRW-1:0] m_ir;
  bit m_ir_q[$];
  bit m_dr_q[$];
  logic [UW-1:0] m_user_out;

  jtag_tap_core #(.IR_WIDTH(IRW), .USER_WIDTH(UW), .IDCODE_VAL(IDV),
                  .OP_EXTEST(4'h0), .OP_IDCODE(4'h1), .OP_SAMPLE(4'h2), .OP_USER(4'h3)) dut (
    .tck(tck), .trst(trst), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
    .bsr_tdi(bsr_tdi), .bsr_tdo(bsr_tdo), .bsr_capture(bsr_capture), .bsr_shift(bsr_shift),
    .bsr_update(bsr_update), .bsr_mode(bsr_mode), .user_dr_in(user_dr_in),
    .user_dr_out(user_dr_out), .user_update(user_update)
  );

  always #5 tck = ~tck;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int kind_of(input logic [IRW-1:0] op);
    if (op == 4'h0 || op == 4'h2) return K_BSR;
    if (op == 4'h3) return K_USER;
`ifdef JTAG_IDCODE_EN
    if (op == 4'h1) return K_ID;
`endif
    return K_BYP;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_ir = RST_OP;
    m_ir_q.delete();
    m_dr_q.delete();
    m_user_out = '0;
  endtask

  // One tck: drive pins, check strobes against the model, then advance the model through the rising edge.
  task automatic tick(input bit t_ms, input bit t_di);
    int k;
    logic [UW-1:0] v;
    @(negedge tck); #1;
    tms = t_ms;
    tdi = t_di;
    bsr_tdo = 1'($urandom_range(0, 1));
    #1;
    k = kind_of(m_ir);
    check("bsr_capture", bsr_capture, (m_state == 3 && k == K_BSR));
    check("bsr_shift", bsr_shift, (m_state == 4 && k == K_BSR));
    check("bsr_update", bsr_update, (m_state == 8 && k == K_BSR));
    check("bsr_mode", bsr_mode, (m_ir == 4'h0));
    check("bsr_tdi", bsr_tdi, t_di);
    check("user_dr_out_hold", user_dr_out, m_user_out);
    case (m_state)
      0: m_ir = RST_OP;
      3: begin
        m_dr_q.delete();
        if (k == K_BYP) m_dr_q.push_back(1'b0);
        if (k == K_ID) for (int i = 0; i < 32; i++) m_dr_q.push_back(IDV[i]);
        if (k == K_USER) for (int i = 0; i < UW; i++) m_dr_q.push_back(user_dr_in[i]);
      end
      4: if (k != K_BSR) begin
        void'(m_dr_q.pop_front());
        m_dr_q.push_back(t_di);
      end
      8: if (k == K_USER) begin
        v = '0;
        for (int i = 0; i < UW; i++) v[i] = m_dr_q[i];
        m_user_out = v;
        upd_q.push_back(v);
      end
      10: begin
        m_ir_q.delete();
        m_ir_q.push_back(1'b1);
        for (int i = 1; i < IRW; i++) m_ir_q.push_back(1'b0);
      end
      11: begin
        void'(m_ir_q.pop_front());
        m_ir_q.push_back(t_di);
      end
      15: for (int i = 0; i < IRW; i++) m_ir[i] = m_ir_q[i];
      default: ;
    endcase
    m_state = t_ms ? NXT1[m_state] : NXT0[m_state];
    if (m_state == 11) exp_q.push_back(m_ir_q[0]);
    else if (m_state == 4) exp_q.push_back(k == K_BSR ? bsr_tdo : m_dr_q[0]);
  endtask

  task automatic do_reset();
    @(posedge tck); #3;
    tms = 1'b1;
    trst = 1'b1;
    #1;
    exp_q.delete();
    upd_q.delete();
    model_reset();
    check("rst_tdo_en", tdo_en, 0);
    check("rst_tdo", tdo, 0);
    check("rst_user_dr_out", user_dr_out, 0);
    check("rst_user_update", user_update, 0);
    check("rst_bsr_mode", bsr_mode, 0);
    check("rst_bsr_strobes", {bsr_capture, bsr_shift, bsr_update}, 0);
    @(negedge tck); #3;
    trst = 1'b0;
  endtask

  // Full IR or DR scan from RTI back to RTI; returns the tdo bits seen, LSB first.
  task automatic scan(input bit is_ir, input int n, input logic [63:0] data,
                      output logic [63:0] got, output int cnt);
    obs_q.delete();
    tick(1, 0);
    if (is_ir) tick(1, 0);
    tick(0, 0);
    tick(0, 0);
    for (int i = 0; i < n; i++) tick(i == n - 1, data[i]);
    tick(1, 0);
    tick(0, 0);
    tick(0, 0);
    got = '0;
    cnt = obs_q.size();
    for (int i = 0; i < obs_q.size() && i < 64; i++) got[i] = obs_q[i];
  endtask

  initial begin
    forever begin
      @(posedge tck); #1;
      if (tdo_en === 1'b1) begin
        obs_q.push_back(tdo);
        if (exp_q.size() == 0) check("tdo_en_spurious", tdo_en, 0);
        else check("tdo", tdo, exp_q.pop_front());
      end
      if (user_update === 1'b1) begin
        upd_seen++;
        if (upd_q.size() == 0) check("user_update_spurious", user_update, 0);
        else check("user_dr_out_at_update", user_dr_out, upd_q.pop_front());
      end
    end
  end

  initial begin
    logic [63:0] got;
    int cnt, u0;
    trst = 1'b1; tms = 1'b1; tdi = 1'b0; bsr_tdo = 1'b0; user_dr_in = '0;
    model_reset();
    do_reset();
    tick(0, 0);

    scan(0, 32, '1, got, cnt);
    check("idcode_cnt", cnt, 32);
`ifdef JTAG_IDCODE_EN
    check("idcode_stream", got[31:0], 32'h1000_0001);
`else
    check("idcode_stream", got[31:0], 32'hFFFF_FFFE);
`endif

    scan(1, 4, 64'h5, got, cnt);
    check("ir_capture_5", got[3:0], 4'b0001);
    scan(1, 4, 64'hF, got, cnt);
    check("ir_capture_f", got[3:0], 4'b0001);
    scan(0, 4, 64'b1101, got, cnt);
    check("bypass_delay", got[3:0], 4'b1010);

    user_dr_in = 8'hA5;
    scan(1, 4, 64'h3, got, cnt);
    u0 = upd_seen;
    scan(0, 8, 64'h3C, got, cnt);
    check("user_capture", got[7:0], 8'hA5);
    check("user_out", user_dr_out, 8'h3C);
    check("user_update_pulses", upd_seen - u0, 1);
    scan(1, 4, 64'hF, got, cnt);
    check("user_out_after_ir_only", user_dr_out, 8'h3C);

    scan(1, 4, 64'h3, got, cnt);
    tick(1, 0); tick(0, 0); tick(0, 0);
    tick(0, 1); tick(0, 1); tick(0, 0);
    do_reset();
    tick(0, 0);
    @(posedge tck); #2;
    check("post_trst_tdo_en", tdo_en, 0);
    check("post_trst_user_out", user_dr_out, 0);
    scan(0, 32, '1, got, cnt);
`ifdef JTAG_IDCODE_EN
    check("post_trst_ir", got[31:0], 32'h1000_0001);
`else
    check("post_trst_ir", got[31:0], 32'hFFFF_FFFE);
`endif

    scan(1, 4, 64'h0, got, cnt);
    check("extest_mode", bsr_mode, 1);
    scan(0, 6, 64'h2D, got, cnt);
    check("extest_cnt", cnt, 6);
    for (int i = 0; i < 5; i++) tick(1, 0);
    @(posedge tck); #2;
    check("tlr_bsr_mode", bsr_mode, 0);
    tick(0, 0);
    scan(1, 4, 64'h2, got, cnt);
    scan(0, 5, 64'h13, got, cnt);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        user_dr_in = UW'($urandom);
        tick($urandom_range(0, 7) < 3, 1'($urandom_range(0, 1)));
      end
    end

    for (int i = 0; i < 6; i++) tick(1, 0);
    repeat (2) @(posedge tck);
    #2;
    check("tdo_queue_drained", exp_q.size(), 0);
    check("update_queue_drained", upd_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
